// File: rtl/slave_mem_pkg.sv
// slave_mem_pkg: state encoding and sizing helpers for the slave memory controller
package slave_mem_pkg;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  localparam int CNT_W = 4;
  // Single-bit rsp_err today; codes kept for a future multi-bit error field
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_DECODE = 2'd1;
  function automatic int calc_ofs(input int data_width);
    return $clog2(data_width / 8);
  endfunction
  function automatic int calc_depth(input int mem_size, input int data_width);
    return mem_size / (data_width / 8);
  endfunction
endpackage

// File: rtl/slave_mem_array.sv
// slave_mem_array: synchronous byte-enabled word RAM, no reset so it maps to block RAM
module slave_mem_array #(
  parameter int DW = 32,
  parameter int DEPTH = 1024,
  parameter int AW = 10
) (
  input  logic            clk,
  input  logic            we,
  input  logic [DW/8-1:0] wstrb,
  input  logic [AW-1:0]   waddr,
  input  logic [DW-1:0]   wdata,
  input  logic [AW-1:0]   raddr,
  output logic [DW-1:0]   rdata
);
  logic [DW-1:0] r_mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we)
      for (int i = 0; i < DW/8; i++)
        if (wstrb[i]) r_mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
    rdata <= r_mem[raddr];
  end
endmodule

// File: rtl/slave_memory_ctrl.sv
// slave_memory_ctrl: valid/ready slave RAM with byte strobes, wait states and decode errors
module slave_memory_ctrl
  import slave_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE = 4096,
  parameter int LATENCY = 1,
  parameter int CHECK_ALIGN = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err
);
  localparam int OFS = calc_ofs(DATA_WIDTH);
  localparam int MEM_DEPTH = calc_depth(MEM_SIZE, DATA_WIDTH);
  localparam int RAW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] OFS_MASK = ADDR_WIDTH'((1 << OFS) - 1);
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY > 0 ? LATENCY - 1 : 0);
  state_t r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [RAW-1:0] r_raddr;
  logic r_req_ready, r_rsp_valid, r_rsp_err, r_rd_ok;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [RAW-1:0] w_raddr;
  logic [DATA_WIDTH-1:0] w_ram_rdata;
  logic w_err, w_we;
  assign w_idx = req_addr >> OFS;
  assign w_err = ({1'b0, w_idx} >= DEPTH_L) || (CHECK_ALIGN != 0 && (req_addr & OFS_MASK) != '0);
  assign w_we = req_valid && r_req_ready && req_write && !w_err;
  // Outside IDLE the RAM keeps re-reading the latched word, so read data holds until the handshake
  assign w_raddr = (r_state == S_IDLE) ? w_idx[RAW-1:0] : r_raddr;
  slave_mem_array #(.DW(DATA_WIDTH), .DEPTH(MEM_DEPTH), .AW(RAW)) u_array (
    .clk(clk),
    .we(w_we),
    .wstrb(req_wstrb),
    .waddr(w_idx[RAW-1:0]),
    .wdata(req_wdata),
    .raddr(w_raddr),
    .rdata(w_ram_rdata)
  );
  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err = r_rsp_err;
  assign rsp_rdata = r_rd_ok ? w_ram_rdata : '0;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_raddr <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err <= 1'b0;
      r_rd_ok <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_raddr <= w_idx[RAW-1:0];
          r_rd_ok <= !req_write && !w_err;
          r_rsp_err <= w_err;
          r_req_ready <= 1'b0;
          r_cnt <= LAT_M1;
          if (LATENCY > 0) r_state <= S_WAIT;
          else begin
            r_state <= S_RESP;
            r_rsp_valid <= 1'b1;
          end
        end
        S_WAIT: if (r_cnt == '0) begin
          r_state <= S_RESP;
          r_rsp_valid <= 1'b1;
        end else r_cnt <= r_cnt - 1'b1;
        S_RESP: if (rsp_ready) begin
          r_state <= S_IDLE;
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
          r_rsp_err <= 1'b0;
          r_rd_ok <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/slave_memory_ctrl.md
Name: slave_memory_ctrl

Overview:
- Parametrised successor to the bus slave memory: word-organised RAM behind a valid/ready request/response handshake.
- Adds byte-strobed writes and a programmable read/write latency via a wait-state counter.
- Adds range and alignment error reporting, with one request outstanding at a time.
- Sits at the slave end of the system bus, behind the slave port adapter.

Parameters:
ADDR_WIDTH, 16, byte address width
DATA_WIDTH, 32, data width in bits; multiple of 8, power of two
MEM_SIZE, 4096, memory size in bytes; MEM_DEPTH = MEM_SIZE/(DATA_WIDTH/8) words
LATENCY, 1, wait states between accept and response, 0..15
CHECK_ALIGN, 1, 1 = flag requests with nonzero byte-offset bits as errors

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  write data
req_wstrb  in  DATA_WIDTH/8  byte enables for writes
rsp_valid  out  1  response valid
rsp_ready  in  1  response taken when valid&ready
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors
rsp_err  out  1  request was out of range or misaligned

Behaviour:
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter 0.
- Reset does not clear memory contents.
- Reset is asynchronous at any point: an in-flight response is dropped. A write accepted before reset remains committed.
- Address decode: OFS = log2(DATA_WIDTH/8) and word index = req_addr[ADDR_WIDTH-1:OFS].
  - err if word index >= MEM_DEPTH.
  - err if CHECK_ALIGN=1 and req_addr[OFS-1:0] != 0.
  - When CHECK_ALIGN=0 the offset bits are ignored.
- FSM states:
  - IDLE: req_ready=1. On req_valid&req_ready at edge E0:
    - Write, no error: bytes with wstrb[i]=1 are written at E0; other bytes are unchanged. wstrb=0 is a legal no-op.
    - Read, no error: the word is captured into the response register at E0.
    - Error: no memory access; response data 0, err=1.
    - Next state: WAIT if LATENCY>0, else RESP.
  - WAIT: req_ready=0. The counter loads LATENCY-1 at E0 and decrements each cycle. At 0 it goes to RESP.
  - RESP: rsp_valid=1, and rsp_rdata/rsp_err are held stable until rsp_ready. On the handshake edge it goes to IDLE.
- Timing:
  - rsp_valid first goes high in the cycle after edge E0+LATENCY. With LATENCY=0 that is the cycle right after accept.
  - The minimum request-to-request spacing is LATENCY+2 cycles, including one IDLE bubble after each response.
- rsp_valid, once raised, is never dropped without a handshake, except on reset.
- req_* inputs are ignored outside IDLE.
- Write responses: rsp_rdata=0, rsp_err per decode.
- Read-after-write to the same address returns the new data, because there is a single outstanding request.
- All outputs are registered. There is no combinational path from req_* to rsp_*.

Decomposition:
- Package slave_mem_pkg:
  - FSM state encoding (IDLE, WAIT, RESP).
  - Width helpers: OFS, MEM_DEPTH, and a counter width of 4.
  - An error-code localparam reserved for future multi-bit errors.
- Sub-module slave_mem_array:
  - Synchronous byte-enabled RAM with ports clk, we, wstrb, waddr, wdata, raddr, rdata.
  - No reset, inferrable as block RAM.
  - The controller instantiates it once and owns the FSM, decode, counter and response register.

Test Plan:
- Reset then LATENCY=1: write 0x0010 data 0xDEADBEEF strb 0xF, then read 0x0010 -> rsp_rdata=0xDEADBEEF, err=0, rsp_valid rises 2 cycles after each accept.
- Byte strobes: write 0x0020 0x11223344 strb 0xF, then write 0x0020 0xAABBCCDD strb 0x5 -> read returns 0x11BB33DD.
- Range/alignment: read 0x1000 (MEM_SIZE=4096) -> err=1, rdata=0. Read 0x0013 with CHECK_ALIGN=1 -> err=1. Write to 0x1000 leaves memory unchanged, checked by readback at 0x0000.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid, rdata and err stay stable, req_ready=0. A new req_valid is ignored until the handshake plus one IDLE cycle.
- Latency sweep LATENCY=0 and 7 -> rsp_valid rises 1 and 8 cycles after accept respectively. Back-to-back requests are spaced LATENCY+2 cycles.
- Reset mid-operation: assert rstn=0 in WAIT after a write of 0xCAFEF00D to 0x0040 -> rsp_valid=0 and req_ready=1 after reset. A later read of 0x0040 returns 0xCAFEF00D.
